// File: rtl/osiris_i_pkg.sv
// rtl/osiris_i_pkg.sv - shared OSIRIS I encodings and pipeline-stage state type
package osiris_i_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

endpackage

// File: rtl/skid_buffer.sv
// rtl/skid_buffer.sv - generic 2-entry valid/ready skid buffer with registered ready
module skid_buffer
  import osiris_i_pkg::*;
#(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [PAYLOAD_W-1:0] i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [PAYLOAD_W-1:0] o_data
);

  stage_state_t         state_q, state_d;
  logic [PAYLOAD_W-1:0] main_q, main_d;
  logic [PAYLOAD_W-1:0] skid_q, skid_d;
  logic                 ready_q, ready_d;
  logic                 acc, deq;

  assign acc = i_valid & ready_q;
  assign deq = (state_q != EMPTY) & i_ready;

  // Next state and register loads; main is the head, skid only fills when the head stalls.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (i_flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d = ONE;
            main_d  = i_data;
          end
        end
        ONE: begin
          if (acc && deq) begin
            main_d = i_data;
          end else if (acc) begin
            state_d = TWO;
            skid_d  = i_data;
          end else if (deq) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (deq) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    ready_d = (state_d != TWO);
  end

  // State, payload and registered ready; reset also clears both payload slots.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = (state_q != EMPTY);
  assign o_data  = main_q;

endmodule

// File: rtl/ex_mem_stage_reg.sv
// rtl/ex_mem_stage_reg.sv - EX->MEM pipeline register with skid, forward tap, optional stall counter (EX_MEM_STALL_CNT_EN)
module ex_mem_stage_reg
  import osiris_i_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid_EX,
  output logic                  o_ready_EX,
  input  logic [WIDTH-1:0]      i_alu_result_EX,
  input  logic [WIDTH-1:0]      i_write_data_EX,
  input  logic [WIDTH-1:0]      i_pc_plus4_EX,
  input  logic [REG_ADDR_W-1:0] i_rd_EX,
  input  logic                  i_reg_write_EX,
  input  logic                  i_mem_write_EX,
  input  logic [1:0]            i_result_src_EX,
  input  logic [2:0]            i_funct3_EX,
  input  logic                  i_flush_MEM,
  output logic                  o_valid_MEM,
  input  logic                  i_ready_MEM,
  output logic [WIDTH-1:0]      o_alu_result_MEM,
  output logic [WIDTH-1:0]      o_write_data_MEM,
  output logic [WIDTH-1:0]      o_pc_plus4_MEM,
  output logic [REG_ADDR_W-1:0] o_rd_MEM,
  output logic                  o_reg_write_MEM,
  output logic                  o_mem_write_MEM,
  output logic [1:0]            o_result_src_MEM,
  output logic [2:0]            o_funct3_MEM,
  output logic                  o_fwd_valid_MEM,
  output logic [REG_ADDR_W-1:0] o_fwd_rd_MEM,
  output logic [WIDTH-1:0]      o_fwd_data_MEM,
  output logic [31:0]           o_stall_cnt
);

  localparam int PW = 3 * WIDTH + REG_ADDR_W + 7;

  logic [PW-1:0] in_bus, out_bus;

  // A write to x0 is architecturally a no-op, so it is dropped at capture time.
  assign in_bus = {i_alu_result_EX, i_write_data_EX, i_pc_plus4_EX, i_rd_EX,
                   i_reg_write_EX & (i_rd_EX != '0), i_mem_write_EX,
                   i_result_src_EX, i_funct3_EX};

  skid_buffer #(.PAYLOAD_W(PW)) u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_flush_MEM),
    .i_valid (i_valid_EX),
    .o_ready (o_ready_EX),
    .i_data  (in_bus),
    .o_valid (o_valid_MEM),
    .i_ready (i_ready_MEM),
    .o_data  (out_bus)
  );

  assign {o_alu_result_MEM, o_write_data_MEM, o_pc_plus4_MEM, o_rd_MEM,
          o_reg_write_MEM, o_mem_write_MEM, o_result_src_MEM, o_funct3_MEM} = out_bus;

  // Only alu results are ready in MEM; loads and pc+4 are resolved later.
  assign o_fwd_valid_MEM = o_valid_MEM & o_reg_write_MEM & (o_result_src_MEM == RES_ALU);
  assign o_fwd_rd_MEM    = o_rd_MEM;
  assign o_fwd_data_MEM  = o_alu_result_MEM;

`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Counts cycles the head waits on MEM; survives flush, wraps naturally.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
    end else if (o_valid_MEM && !i_ready_MEM) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`else
  assign o_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// tb/tb_ex_mem_stage_reg.sv - randomized and directed bench for ex_mem_stage_reg against a queue model
module tb_ex_mem_stage_reg;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
    logic [2:0]  f3;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_ex, ready_ex;
  logic [31:0] alu_ex, wd_ex, pc4_ex;
  logic [4:0]  rd_ex;
  logic        rw_ex, mw_ex;
  logic [1:0]  rs_ex;
  logic [2:0]  f3_ex;
  logic        flush, valid_mem, ready_mem;
  logic [31:0] alu_m, wd_m, pc4_m;
  logic [4:0]  rd_m;
  logic        rw_m, mw_m;
  logic [1:0]  rs_m;
  logic [2:0]  f3_m;
  logic        fwd_v;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data, stall_cnt;

  int errors = 0;
  int checks = 0;

  beat_t       mq[$];
  bit          m_ready = 1'b1;
  logic [31:0] m_cnt = 32'd0;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  ex_mem_stage_reg #(.WIDTH(32), .REG_ADDR_W(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid_EX(valid_ex), .o_ready_EX(ready_ex),
    .i_alu_result_EX(alu_ex), .i_write_data_EX(wd_ex), .i_pc_plus4_EX(pc4_ex),
    .i_rd_EX(rd_ex), .i_reg_write_EX(rw_ex), .i_mem_write_EX(mw_ex),
    .i_result_src_EX(rs_ex), .i_funct3_EX(f3_ex), .i_flush_MEM(flush),
    .o_valid_MEM(valid_mem), .i_ready_MEM(ready_mem),
    .o_alu_result_MEM(alu_m), .o_write_data_MEM(wd_m), .o_pc_plus4_MEM(pc4_m),
    .o_rd_MEM(rd_m), .o_reg_write_MEM(rw_m), .o_mem_write_MEM(mw_m),
    .o_result_src_MEM(rs_m), .o_funct3_MEM(f3_m),
    .o_fwd_valid_MEM(fwd_v), .o_fwd_rd_MEM(fwd_rd), .o_fwd_data_MEM(fwd_data),
    .o_stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a FIFO of at most two beats; ready means room remains after this cycle.
  task automatic model_update();
    beat_t b;
    bit    acc, deq;
    if (!rst_n) begin
      mq.delete();
      m_ready = 1'b1;
      m_cnt   = 32'd0;
    end else begin
`ifdef EX_MEM_STALL_CNT_EN
      if (mq.size() != 0 && !ready_mem) m_cnt = m_cnt + 32'd1;
`endif
      if (flush) begin
        mq.delete();
        m_ready = 1'b1;
      end else begin
        acc = valid_ex && m_ready;
        deq = (mq.size() != 0) && ready_mem;
        if (deq) void'(mq.pop_front());
        if (acc) begin
          b = '{alu: alu_ex, wd: wd_ex, pc4: pc4_ex, rd: rd_ex,
                rw: rw_ex && (rd_ex != 5'd0), mw: mw_ex, rs: rs_ex, f3: f3_ex};
          mq.push_back(b);
        end
        m_ready = (mq.size() < 2);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Compare process: every cycle, DUT against model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", {31'd0, valid_mem}, {31'd0, mq.size() != 0});
      chk("m_ready", {31'd0, ready_ex}, {31'd0, m_ready});
      chk("m_stall", stall_cnt, m_cnt);
      if (mq.size() != 0) begin
        chk("m_alu", alu_m, mq[0].alu);
        chk("m_wd", wd_m, mq[0].wd);
        chk("m_pc4", pc4_m, mq[0].pc4);
        chk("m_ctl", {19'd0, rd_m, rw_m, mw_m, rs_m, f3_m},
            {19'd0, mq[0].rd, mq[0].rw, mq[0].mw, mq[0].rs, mq[0].f3});
        chk("m_fwd_v", {31'd0, fwd_v}, {31'd0, mq[0].rw && mq[0].rs == 2'b00});
        chk("m_fwd_rd", {27'd0, fwd_rd}, {27'd0, mq[0].rd});
        chk("m_fwd_data", fwd_data, mq[0].alu);
      end else begin
        chk("m_fwd_v_empty", {31'd0, fwd_v}, 32'd0);
      end
    end
  end

  task automatic set_beat(input logic [31:0] a, input logic [4:0] rd, input logic rw, input logic [1:0] rs);
    valid_ex = 1'b1; alu_ex = a; wd_ex = a ^ 32'h5555_0000; pc4_ex = a + 32'd4;
    rd_ex = rd; rw_ex = rw; mw_ex = 1'b0; rs_ex = rs; f3_ex = 3'd2;
  endtask

  initial begin
    logic [31:0] exp_stall;
    rst_n = 1'b0; valid_ex = 1'b1; flush = 1'b0; ready_mem = 1'b1;
    alu_ex = 32'hFFFF_FFFF; wd_ex = 32'hFFFF_FFFF; pc4_ex = 32'hFFFF_FFFF;
    rd_ex = 5'd7; rw_ex = 1'b1; mw_ex = 1'b1; rs_ex = 2'b00; f3_ex = 3'd7;

    // 1. reset held two cycles with valid high
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_valid", {31'd0, valid_mem}, 32'd0);
    chk("rst_ready", {31'd0, ready_ex}, 32'd1);
    chk("rst_payload", alu_m | wd_m | pc4_m | {19'd0, rd_m, rw_m, mw_m, rs_m, f3_m}, 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);

    // 2. back-to-back stream with MEM always ready
    rst_n = 1'b1;
    set_beat(32'h11, 5'd1, 1'b1, 2'b00); tick();
    chk("s_alu0", alu_m, 32'h11);
    set_beat(32'h22, 5'd2, 1'b1, 2'b00); tick();
    chk("s_alu1", alu_m, 32'h22);
    set_beat(32'h33, 5'd3, 1'b1, 2'b00); tick();
    chk("s_alu2", alu_m, 32'h33);
    chk("s_ready", {31'd0, ready_ex}, 32'd1);
    valid_ex = 1'b0; tick();
    chk("s_empty", {31'd0, valid_mem}, 32'd0);

    // 3. backpressure fills the skid
    ready_mem = 1'b0;
    set_beat(32'hA, 5'd4, 1'b1, 2'b00); tick();
    set_beat(32'hB, 5'd4, 1'b1, 2'b00); tick();
    valid_ex = 1'b0;
    chk("bp_ready", {31'd0, ready_ex}, 32'd0);
    chk("bp_head", alu_m, 32'hA);
    tick();
    chk("bp_head_stable", alu_m, 32'hA);
    ready_mem = 1'b1; tick();
    chk("bp_second", alu_m, 32'hB);
    chk("bp_ready_back", {31'd0, ready_ex}, 32'd1);
    tick();
    chk("bp_drained", {31'd0, valid_mem}, 32'd0);

    // 4. x0 destination is never a register write nor forwarded
    set_beat(32'hDEAD, 5'd0, 1'b1, 2'b00); tick();
    chk("x0_rw", {31'd0, rw_m}, 32'd0);
    chk("x0_fwd", {31'd0, fwd_v}, 32'd0);
    set_beat(32'hDEAD, 5'd5, 1'b1, 2'b00); tick();
    chk("r5_fwd_v", {31'd0, fwd_v}, 32'd1);
    chk("r5_fwd_rd", {27'd0, fwd_rd}, 32'd5);
    chk("r5_fwd_data", fwd_data, 32'hDEAD);
    set_beat(32'hBEEF, 5'd6, 1'b1, 2'b01); tick();
    chk("load_no_fwd", {31'd0, fwd_v}, 32'd0);
    valid_ex = 1'b0; tick();

    // 5. flush while in TWO with a beat offered
    ready_mem = 1'b0;
    set_beat(32'h1, 5'd1, 1'b1, 2'b00); tick();
    set_beat(32'h2, 5'd1, 1'b1, 2'b00); tick();
    set_beat(32'h3, 5'd1, 1'b1, 2'b00); flush = 1'b1; tick();
    flush = 1'b0; valid_ex = 1'b0;
    chk("fl_valid", {31'd0, valid_mem}, 32'd0);
    chk("fl_ready", {31'd0, ready_ex}, 32'd1);
    ready_mem = 1'b1; tick(); tick();
    chk("fl_gone", {31'd0, valid_mem}, 32'd0);

    // 6. stall counter over seven blocked cycles
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    ready_mem = 1'b0;
    set_beat(32'h77, 5'd7, 1'b1, 2'b00); tick();
    valid_ex = 1'b0;
    repeat (7) tick();
`ifdef EX_MEM_STALL_CNT_EN
    exp_stall = 32'd7;
`else
    exp_stall = 32'd0;
`endif
    chk("stall7", stall_cnt, exp_stall);
    ready_mem = 1'b1; tick();

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      valid_ex  = ($urandom_range(0, 9) < 7);
      ready_mem = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      rst_n     = ($urandom_range(0, 199) != 0);
      alu_ex = $urandom; wd_ex = $urandom; pc4_ex = $urandom;
      rd_ex  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rw_ex  = 1'($urandom); mw_ex = 1'($urandom);
      rs_ex  = 2'($urandom_range(0, 2)); f3_ex = 3'($urandom);
      tick();
    end
    flush = 1'b0; rst_n = 1'b1; valid_ex = 1'b0; ready_mem = 1'b1;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
